// File: rtl/title_type_sequencer.sv
// Title typewriter scheduler: types letters in, holds the full line with a blinking cursor, erases, repeats.
// Latency: vsync edge -> tick 1 clk -> outputs 1 clk later; no backpressure, all outputs registered.
module title_type_sequencer #(
  parameter int NUM_LETTERS     = 17,
  parameter int FRAMES_PER_CHAR = 8,
  parameter int HOLD_FRAMES     = 180,
  parameter int BLINK_FRAMES    = 30,
  parameter int VSYNC_ACT_LOW   = 1,
  localparam int IW             = $clog2(NUM_LETTERS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vsync,
  input  logic                   enable,
  input  logic                   restart,
  output logic [NUM_LETTERS-1:0] letter_en,
  output logic [IW-1:0]          cursor_idx,
  output logic                   cursor_on,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TYPE  = 2'b01,
    S_HOLD  = 2'b10,
    S_ERASE = 2'b11
  } state_e;

  localparam int FMAX = (FRAMES_PER_CHAR > HOLD_FRAMES) ? FRAMES_PER_CHAR : HOLD_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int BW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [FW-1:0] FPC_LAST   = FW'(FRAMES_PER_CHAR - 1);
  localparam logic [FW-1:0] HOLD_LAST  = FW'(HOLD_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [IW-1:0] IDX_FULL   = IW'(NUM_LETTERS);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_LETTERS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  // vsync normalised so that 1 always means "active"
  logic vs_act;
  logic vs_act_q;
  logic tick_q;

  assign vs_act = (VSYNC_ACT_LOW != 0) ? ~vsync : vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      vs_act_q <= vs_act;
      tick_q   <= vs_act & ~vs_act_q;
    end
  end

  state_e                 state_q, state_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic                   phase_q, phase_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_LETTERS-1:0] letter_en_q, letter_en_d;
  logic                   cursor_on_q, cursor_on_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      idx_q       <= '0;
      letter_en_q <= '0;
      cursor_on_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      letter_en_q <= letter_en_d;
      cursor_on_q <= cursor_on_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    bcnt_d      = bcnt_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    letter_en_d = '0;
    cursor_on_d = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      fcnt_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b0;
      idx_d   = '0;
    end else if (restart) begin
      // any frame tick arriving together with restart is dropped here
      state_d = S_TYPE;
      fcnt_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b1;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_TYPE;
          fcnt_d  = '0;
          idx_d   = '0;
        end
        S_TYPE: begin
          if (idx_q >= IDX_FULL) begin
            state_d = S_HOLD;
            idx_d   = IDX_FULL;
            bcnt_d  = '0;
            phase_d = 1'b1;
          end else if (tick_q) begin
            if (fcnt_q == FPC_LAST) begin
              fcnt_d = '0;
              idx_d  = idx_q + IDX_ONE;
              if (idx_q == IDX_LAST) begin
                state_d = S_HOLD;
                bcnt_d  = '0;
                phase_d = 1'b1;
              end
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (tick_q) begin
            if (bcnt_q == BLINK_LAST) begin
              bcnt_d  = '0;
              phase_d = ~phase_q;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
            if (fcnt_q == HOLD_LAST) begin
              fcnt_d  = '0;
              state_d = S_ERASE;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        S_ERASE: begin
          if (tick_q) begin
            if (idx_q != '0) begin
              idx_d = idx_q - IDX_ONE;
            end
            if (idx_q <= IDX_ONE) begin
              state_d = S_TYPE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      fcnt_d = '0;
    end

    // mask is derived from the cursor so it can only ever be a thermometer code
    for (int i = 0; i < NUM_LETTERS; i++) begin
      letter_en_d[i] = (IW'(i) < idx_d);
    end

    unique case (state_d)
      S_TYPE, S_ERASE: cursor_on_d = 1'b1;
      S_HOLD:          cursor_on_d = phase_d;
      default:         cursor_on_d = 1'b0;
    endcase
  end

  assign letter_en  = letter_en_q;
  assign cursor_idx = idx_q;
  assign cursor_on  = cursor_on_q;
  assign state      = state_q;

endmodule
